// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and defaults for the LFSR burst sequencer.
package lfsr_ctrl_pkg;

   localparam int         LFSR_WIDTH     = 8;
   localparam int         LFSR_LEN_W     = 8;
   localparam logic [7:0] LFSR_SAFE_SEED = 8'h01;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } state_t;

endpackage

// File: rtl/lfsr_burst_ctrl.sv
// Loads an external LFSR with a command seed, then streams `length` words with
// back-pressure. The LFSR free-runs unless enabled, so every stall reloads its value.
//
// state  | meaning
// IDLE   | LFSR held, waiting for a command
// LOAD   | seed written into the LFSR (one cycle)
// STREAM | LFSR word presented; steps only on handshake
module lfsr_burst_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int               WIDTH     = LFSR_WIDTH,
   parameter int               LEN_W     = LFSR_LEN_W,
   parameter logic [WIDTH-1:0] SAFE_SEED = WIDTH'(LFSR_SAFE_SEED)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_seed,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             seed_fixed,
   output logic             lfsr_reset,
   output logic             lfsr_enable,
   output logic [WIDTH-1:0] lfsr_seed,
   input  logic [WIDTH-1:0] lfsr_value
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             seed_fixed_q, seed_fixed_d;
   logic             lfsr_reset_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         seed_q       <= '0;
         remaining_q  <= '0;
         seed_fixed_q <= 1'b0;
         lfsr_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         seed_q       <= seed_d;
         remaining_q  <= remaining_d;
         seed_fixed_q <= seed_fixed_d;
         lfsr_reset_q <= 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      seed_d       = seed_q;
      remaining_d  = remaining_q;
      seed_fixed_d = 1'b0;
      cmd_ready    = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      lfsr_enable  = 1'b1;
      lfsr_seed    = lfsr_value;
      case (state_q)
         IDLE: begin
            cmd_ready = !lfsr_reset_q && !abort;
            if (cmd_valid && cmd_ready) begin
               seed_fixed_d = (cmd_seed == '0);
               seed_d       = seed_fixed_d ? SAFE_SEED : cmd_seed;
               // cmd_len of zero wraps to the full 2^LEN_W burst
               remaining_d  = cmd_len - LEN_W'(1);
               state_d      = LOAD;
            end
         end
         LOAD: begin
            lfsr_seed = seed_q;
            state_d   = abort ? IDLE : STREAM;
         end
         STREAM: begin
            out_valid = 1'b1;
            out_last  = (remaining_q == '0);
            if (out_ready) begin
               lfsr_enable = 1'b0;
               if (out_last) state_d = IDLE;
               else remaining_d = remaining_q - LEN_W'(1);
            end
            if (abort) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_data   = lfsr_value;
   assign busy       = (state_q != IDLE);
   assign seed_fixed = seed_fixed_q;
   assign lfsr_reset = lfsr_reset_q;

endmodule
